hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Sits beside the ID stage. It produces the bubble select that zeroes the ID control word (sel_mux_cu), and the PC / IF-ID write enables and flushes.
- Detects and resolves these hazards:
  - load-use hazards;
  - taken branches and jumps;
  - multi-cycle mul/div issue, via a counter-based FSM;
  - data-memory wait states, via a freeze.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch/jump, mul/div and dmem-wait stall control with a saturating stall counter
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              id_muldiv,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              sel_mux_cu,
    output logic              pipe_freeze,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cnt
);
    localparam logic [0:0] RUN         = 1'b0;
    localparam logic [0:0] MULDIV_WAIT = 1'b1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              freeze, load_use;

    always_comb begin
        freeze      = dmem_req && !dmem_ready;
        load_use    = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        sel_mux_cu  = 1'b0;
        pipe_freeze = 1'b0;
        muldiv_busy = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        // outputs stay at their idle values for as long as reset is held
        if (rst_n) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                sel_mux_cu  = 1'b1;
                state_d     = RUN;
                cnt_d       = '0;
            end else if (state_q == MULDIV_WAIT) begin
                pc_write    = cnt_q == '0;
                if_id_write = cnt_q == '0;
                sel_mux_cu  = cnt_q != '0;
                muldiv_busy = cnt_q != '0;
                state_d     = (cnt_q == '0) ? RUN : MULDIV_WAIT;
                cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                sel_mux_cu  = 1'b1;
            end else if (id_muldiv) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                sel_mux_cu  = 1'b1;
                muldiv_busy = 1'b1;
                state_d     = MULDIV_WAIT;
                cnt_d       = LAT_M1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end
        stall_cnt_d = (!pc_write && (stall_cnt_q != '1)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three parameterisations driven in lockstep and checked against a cycle-level reference model
module tb_hazard_ctrl;
    logic       clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, id_muldiv, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
    logic       pw [3], ifw [3], fl [3], sel [3], fz [3], busy [3];
    logic [31:0] sc_a, sc_b;
    logic [3:0]  sc_c;
    int vec_cnt = 0, err_cnt = 0;

    // reference state: whether a mul/div sequence is open and how many stall cycles it has served
    int     lat  [3] = '{4, 1, 7};
    longint smax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    bit     in_md [3];
    int     served [3];
    longint st [3];

    hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3), .PERF_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pw[0]), .if_id_write(ifw[0]), .if_id_flush(fl[0]), .sel_mux_cu(sel[0]),
        .pipe_freeze(fz[0]), .muldiv_busy(busy[0]), .stall_cnt(sc_a));
    hazard_ctrl #(.MULDIV_LAT(1), .CNT_W(3), .PERF_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pw[1]), .if_id_write(ifw[1]), .if_id_flush(fl[1]), .sel_mux_cu(sel[1]),
        .pipe_freeze(fz[1]), .muldiv_busy(busy[1]), .stall_cnt(sc_b));
    hazard_ctrl #(.MULDIV_LAT(7), .CNT_W(3), .PERF_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pw[2]), .if_id_write(ifw[2]), .if_id_flush(fl[2]), .sel_mux_cu(sel[2]),
        .pipe_freeze(fz[2]), .muldiv_busy(busy[2]), .stall_cnt(sc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rt, id_jump, id_muldiv, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready} = '0;
    endtask

    // check one cycle of all three DUTs, advance the model, move to the next falling edge
    task automatic cyc();
        logic [5:0]  e;
        logic [63:0] got_sc;
        bit lu;
        #1;
        lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                in_md[k] = 0; served[k] = 0; st[k] = 0;
            end
            e = 6'b110000;
            if (!rst_n) e = 6'b110000;
            else if (dmem_req && !dmem_ready) e = 6'b000010;
            else if (ex_branch_taken) begin e = 6'b111100; in_md[k] = 0; end
            else if (in_md[k] && served[k] < lat[k]) begin e = 6'b000101; served[k]++; end
            else if (in_md[k]) in_md[k] = 0;
            else if (lu) e = 6'b000100;
            else if (id_muldiv) begin e = 6'b000101; in_md[k] = 1; served[k] = 1; end
            else if (id_jump) e = 6'b111000;
            got_sc = (k == 0) ? 64'(sc_a) : (k == 1) ? 64'(sc_b) : 64'(sc_c);
            chk($sformatf("ctl%0d", k), 64'({pw[k], ifw[k], fl[k], sel[k], fz[k], busy[k]}), 64'(e));
            chk($sformatf("stall_cnt%0d", k), got_sc, 64'(st[k]));
            if (rst_n && !e[5] && st[k] < smax[k]) st[k]++;
        end
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        @(negedge clk);
        repeat (2) begin
            {id_rs, id_rt, ex_rt} = 15'($urandom);
            {id_uses_rt, id_jump, id_muldiv, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready} = 7'($urandom);
            cyc();
        end
        rst_n = 1'b1;
        clr(); cyc();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5; cyc();
        clr(); cyc();
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; cyc();
        ex_rt = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0; cyc();
        id_uses_rt = 1; cyc();
        clr(); id_muldiv = 1; repeat (5) cyc();
        clr(); repeat (8) cyc();
        id_muldiv = 1; cyc();
        id_muldiv = 0; ex_branch_taken = 1; cyc();
        clr(); repeat (2) cyc();
        id_muldiv = 1; cyc();
        id_muldiv = 0; cyc();
        dmem_req = 1; repeat (3) cyc();
        dmem_ready = 1; repeat (4) cyc();
        clr(); repeat (4) cyc();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_jump = 1; cyc();
        clr(); id_muldiv = 1; cyc(); cyc();
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; clr(); cyc();
        ex_mem_read = 1; ex_rt = 3; id_rs = 3; repeat (20) cyc();
        chk("stall_cnt_sat", 64'(sc_c), 64'd15);
        clr(); cyc();
        repeat (3000) begin
            rst_n = ($urandom_range(0, 99) != 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            id_muldiv = ($urandom_range(0, 3) == 0);
            id_jump = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            dmem_req = ($urandom_range(0, 4) == 0);
            dmem_ready = 1'($urandom);
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
